life_grid_reader: RTL and testbench

//  Reader end of the LifeCell array: snapshots the alive outputs of a ROWSxCOLS

---
 rtl/life_grid_reader.sv | 159 +++++++++++++++
 tb/tb_life_grid_reader.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/life_grid_reader.sv
// life_grid_reader: snapshots the LifeCell alive grid once per generation (phase 0) and streams it row by row.
// Latency: first row valid one cycle after the phase-0 capture; one row per accepted beat thereafter.
// Backpressure: beat held stable until accepted; a capture point that arrives mid-stream is skipped and flagged in overrun.
module life_grid_reader #(
    parameter  int ROWS       = 8,
    parameter  int COLS       = 8,
    parameter  int GEN_CYCLES = 8,
    parameter  int GEN_W      = 16,
    localparam int ROW_W      = (ROWS > 1) ? $clog2(ROWS) : 1,
    localparam int POP_W      = $clog2(ROWS * COLS + 1),
    localparam int PH_W       = (GEN_CYCLES > 1) ? $clog2(GEN_CYCLES) : 1
) (
    input  logic                   clk,
    input  logic                   nrst,
    input  logic [ROWS*COLS-1:0]   cells_alive,
    output logic [COLS-1:0]        out_data,
    output logic [ROW_W-1:0]       out_row,
    output logic [GEN_W-1:0]       out_gen,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   out_last,
    output logic [POP_W-1:0]       pop_count,
    output logic                   overrun
);

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_STREAM = 1'b1
    } state_t;

    state_t                 state_q,   state_d;
    logic [PH_W-1:0]        phase_q,   phase_d;
    logic [GEN_W-1:0]       gen_q,     gen_d;
    logic                   seeded_q,  seeded_d;
    logic [ROWS*COLS-1:0]   snap_q,    snap_d;
    logic [ROW_W-1:0]       row_q,     row_d;
    logic [GEN_W-1:0]       out_gen_q, out_gen_d;
    logic [POP_W-1:0]       acc_q,     acc_d;
    logic [POP_W-1:0]       pop_q,     pop_d;
    logic                   overrun_q, overrun_d;

    logic                   capture;
    logic                   accept;
    logic                   last_row;
    logic [COLS-1:0]        row_dat;
    logic [POP_W-1:0]       row_pop;

    function automatic logic [POP_W-1:0] popcount_row(input logic [COLS-1:0] v);
        logic [POP_W-1:0] n;
        n = '0;
        for (int i = 0; i < COLS; i++) begin
            n = n + POP_W'(v[i]);
        end
        return n;
    endfunction

    // Row selection, capture/accept strobes and the row's population
    always_comb begin
        row_dat  = snap_q[int'(row_q) * COLS +: COLS];
        row_pop  = popcount_row(row_dat);
        capture  = (phase_q == '0);
        accept   = (state_q == ST_STREAM) && out_ready;
        last_row = (row_q == ROW_W'(ROWS - 1));
    end

    // Phase counter runs in lock-step with the cell FSM; generation counts captures after the seed
    always_comb begin
        phase_d  = (phase_q == PH_W'(GEN_CYCLES - 1)) ? '0 : phase_q + 1'b1;
        gen_d    = gen_q;
        seeded_d = seeded_q;
        if (capture) begin
            seeded_d = 1'b1;
            if (seeded_q) begin
                gen_d = gen_q + 1'b1;
            end
        end
    end

    // Stream FSM: capture in IDLE, walk the rows on accepted beats, publish population at the end
    always_comb begin
        state_d   = state_q;
        snap_d    = snap_q;
        row_d     = row_q;
        out_gen_d = out_gen_q;
        acc_d     = acc_q;
        pop_d     = pop_q;
        overrun_d = overrun_q;
        case (state_q)
            ST_IDLE: begin
                if (capture) begin
                    snap_d    = cells_alive;
                    out_gen_d = gen_d;
                    row_d     = '0;
                    acc_d     = '0;
                    state_d   = ST_STREAM;
                end
            end
            ST_STREAM: begin
                // A generation arriving while the previous one is still draining is dropped
                if (capture) begin
                    overrun_d = 1'b1;
                end
                if (accept) begin
                    if (last_row) begin
                        pop_d   = acc_q + row_pop;
                        acc_d   = '0;
                        row_d   = '0;
                        state_d = ST_IDLE;
                    end else begin
                        acc_d = acc_q + row_pop;
                        row_d = row_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!nrst) begin
            state_q   <= ST_IDLE;
            phase_q   <= '0;
            gen_q     <= '0;
            seeded_q  <= 1'b0;
            snap_q    <= '0;
            row_q     <= '0;
            out_gen_q <= '0;
            acc_q     <= '0;
            pop_q     <= '0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            phase_q   <= phase_d;
            gen_q     <= gen_d;
            seeded_q  <= seeded_d;
            snap_q    <= snap_d;
            row_q     <= row_d;
            out_gen_q <= out_gen_d;
            acc_q     <= acc_d;
            pop_q     <= pop_d;
            overrun_q <= overrun_d;
        end
    end

    // Output mapping
    always_comb begin
        out_valid = (state_q == ST_STREAM);
        out_last  = (state_q == ST_STREAM) && last_row;
        out_data  = row_dat;
        out_row   = row_q;
        out_gen   = out_gen_q;
        pop_count = pop_q;
        overrun   = overrun_q;
    end

endmodule

// File: tb/tb_life_grid_reader.sv
// Testbench for life_grid_reader: scoreboard of expected beats built by a generation-level reference model.
// Stimulus drives inputs 1 time unit after the rising edge; model and monitor sample on the falling edge.
// Directed scenarios (blinker, full grid, backpressure, long stall, mid-stream reset) followed by random traffic.
module tb_life_grid_reader;
    localparam int ROWS       = 8;
    localparam int COLS       = 8;
    localparam int GEN_CYCLES = 8;
    localparam int GEN_W      = 4;
    localparam int N          = ROWS * COLS;

    logic             clk = 1'b0;
    logic             nrst = 1'b0;
    logic             out_ready = 1'b0;
    logic [N-1:0]     cells_alive = '0;
    logic [COLS-1:0]  out_data;
    logic [2:0]       out_row;
    logic [GEN_W-1:0] out_gen;
    logic             out_valid;
    logic             out_last;
    logic [6:0]       pop_count;
    logic             overrun;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    life_grid_reader #(
        .ROWS(ROWS), .COLS(COLS), .GEN_CYCLES(GEN_CYCLES), .GEN_W(GEN_W)
    ) dut (
        .clk(clk), .nrst(nrst), .cells_alive(cells_alive),
        .out_data(out_data), .out_row(out_row), .out_gen(out_gen),
        .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
        .pop_count(pop_count), .overrun(overrun)
    );

    typedef struct {
        logic [COLS-1:0] data;
        int              row;
        int              gen;
        logic            last;
    } beat_t;

    beat_t exp_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Conway step on a bounded (dead-edge) grid: drives the cell array between generations
    function automatic logic [N-1:0] life_step(input logic [N-1:0] g);
        logic [N-1:0] n;
        int cnt, rr, cc;
        n = '0;
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                cnt = 0;
                for (int dr = -1; dr <= 1; dr++) begin
                    for (int dc = -1; dc <= 1; dc++) begin
                        rr = r + dr;
                        cc = c + dc;
                        if (!(dr == 0 && dc == 0) && rr >= 0 && rr < ROWS && cc >= 0 && cc < COLS)
                            cnt += int'(g[rr*COLS+cc]);
                    end
                end
                n[r*COLS+c] = (cnt == 3) || (g[r*COLS+c] && cnt == 2);
            end
        end
        return n;
    endfunction

    // Reference model: generations, captures, remaining beats, overrun and population
    int   m_cyc = 0, m_gen = 0, m_busy = 0, m_pop = 0, m_pop_pend = 0;
    bit   m_seeded = 0, m_over = 0, prev_rst = 0;

    always @(negedge clk) begin
        int busy0;
        beat_t b;
        if (prev_rst) begin
            check("rst_valid", 64'(out_valid), 64'd0);
            check("rst_last", 64'(out_last), 64'd0);
            check("rst_row", 64'(out_row), 64'd0);
            check("rst_data", 64'(out_data), 64'd0);
            check("rst_gen", 64'(out_gen), 64'd0);
            check("rst_pop", 64'(pop_count), 64'd0);
            check("rst_overrun", 64'(overrun), 64'd0);
        end
        if (!nrst) begin
            m_cyc = 0; m_gen = 0; m_busy = 0; m_pop = 0; m_pop_pend = 0;
            m_seeded = 0; m_over = 0; prev_rst = 1;
            exp_q.delete();
        end else begin
            prev_rst = 0;
            check("valid", 64'(out_valid), 64'(m_busy > 0));
            check("overrun", 64'(overrun), 64'(m_over));
            check("pop_count", 64'(pop_count), 64'(m_pop));
            busy0 = m_busy;
            if (busy0 > 0 && out_ready) begin
                m_busy--;
                if (m_busy == 0) m_pop = m_pop_pend;
            end
            if (m_cyc % GEN_CYCLES == 0) begin
                if (m_seeded) m_gen = (m_gen + 1) % (1 << GEN_W);
                m_seeded = 1;
                if (busy0 > 0) begin
                    m_over = 1;
                end else begin
                    for (int r = 0; r < ROWS; r++) begin
                        b.data = cells_alive[r*COLS +: COLS];
                        b.row  = r;
                        b.gen  = m_gen;
                        b.last = (r == ROWS - 1);
                        exp_q.push_back(b);
                    end
                    m_busy     = ROWS;
                    m_pop_pend = $countones(cells_alive);
                end
            end
            m_cyc++;
        end
    end

    // Monitor: pops the scoreboard on every accepted beat and checks held beats stay put
    bit    hold_pend = 0;
    beat_t hold;

    always @(negedge clk) begin
        beat_t e;
        if (!nrst) begin
            hold_pend = 0;
        end else begin
            if (hold_pend) begin
                check("hold_valid", 64'(out_valid), 64'd1);
                check("hold_data", 64'(out_data), 64'(hold.data));
                check("hold_row", 64'(out_row), 64'(hold.row));
                check("hold_gen", 64'(out_gen), 64'(hold.gen));
                check("hold_last", 64'(out_last), 64'(hold.last));
            end
            hold_pend = 0;
            if (out_valid && !out_ready) begin
                hold_pend = 1;
                hold.data = out_data;
                hold.row  = int'(out_row);
                hold.gen  = int'(out_gen);
                hold.last = out_last;
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_beat: got row %0d data %0h, expected no beat at %0t",
                             out_row, out_data, $time);
                end else begin
                    e = exp_q.pop_front();
                    check("beat_data", 64'(out_data), 64'(e.data));
                    check("beat_row", 64'(out_row), 64'(e.row));
                    check("beat_gen", 64'(out_gen), 64'(e.gen));
                    check("beat_last", 64'(out_last), 64'(e.last));
                end
            end
        end
    end

    // Stimulus
    int k = 0;
    bit life_mode = 0;

    task automatic tick();
        @(posedge clk);
        #1;
        k++;
        if (life_mode && (k % GEN_CYCLES == 0)) cells_alive = life_step(cells_alive);
    endtask

    task automatic do_reset(input int n);
        nrst = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
        nrst = 1'b1;
        k = 0;
    endtask

    task automatic wait_row(input int r);
        int n = 0;
        while (!(out_valid && out_row == 3'(r)) && n < 100) begin
            tick();
            n++;
        end
        checks++;
        if (n >= 100) begin
            errors++;
            $display("FAIL wait_row: row %0d never became valid within 100 cycles", r);
        end
    endtask

    initial begin
        logic [N-1:0] seed;
        // Blinker evolving through the Life rule, sink always ready
        seed = '0;
        seed[3*COLS +: COLS] = 8'b0001_1100;
        cells_alive = seed;
        out_ready = 1'b1;
        life_mode = 1;
        do_reset(3);
        repeat (24) tick();
        check("blinker_pop", 64'(pop_count), 64'd3);
        repeat (40) tick();
        life_mode = 0;

        // Fully populated grid
        cells_alive = '1;
        do_reset(2);
        repeat (4) tick();
        check("full_overrun_early", 64'(overrun), 64'd0);
        repeat (5) tick();
        check("full_pop", 64'(pop_count), 64'd64);
        repeat (20) tick();

        // Backpressure on row 2 for three cycles
        cells_alive = {$urandom, $urandom};
        do_reset(1);
        wait_row(2);
        out_ready = 1'b0;
        repeat (3) tick();
        out_ready = 1'b1;
        repeat (30) tick();

        // Long stall: generations skipped, original snapshot still delivered
        cells_alive = {$urandom, $urandom};
        out_ready = 1'b0;
        do_reset(1);
        repeat (20) tick();
        check("stall_overrun", 64'(overrun), 64'd1);
        out_ready = 1'b1;
        repeat (40) tick();

        // Reset while row 4 is on the bus, then a fresh seed
        cells_alive = {$urandom, $urandom};
        do_reset(1);
        wait_row(4);
        nrst = 1'b0;
        tick();
        cells_alive = {$urandom, $urandom};
        do_reset(1);
        repeat (30) tick();

        // Enough generations for the 4-bit generation counter to wrap
        cells_alive = {$urandom, $urandom};
        do_reset(1);
        out_ready = 1'b0;
        repeat (8) tick();
        out_ready = 1'b1;
        repeat (GEN_CYCLES * 40) tick();

        // Random traffic: random grid every cycle, random ready, occasional reset
        for (int i = 0; i < 1500; i++) begin
            cells_alive = {$urandom, $urandom};
            out_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 399) == 0) do_reset(1);
            else tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish, expected completion before 1000000");
        $fatal(1, "timeout");
    end

endmodule
